// File: rtl/pipe_trace_buffer.sv
// pipe_trace_buffer
//   Debug trace capture block for the five-stage pipelined CPU. When armed,
//   it records DEPTH consecutive cycles of {PC, IF_Inst, WB_Alu}. Recording
//   starts either on a PC match or at once. The window is then drained as a
//   stream of 32-bit words over a valid/ready handshake.
//
// Ports
//   Clock, Resetn      : system clock (rising edge), async active-low reset
//   Arm                : one-cycle request to open a new capture window
//   TrigEn, TrigPC     : wait for PC==TrigPC (TrigEn=1) or capture at once
//   PC, IF_Inst, WB_Alu: CPU observation bus, sampled every cycle
//   Rd_Data/Valid/Last : readout stream; Rd_Ready is the consumer's accept
//   State              : IDLE=0, ARMED=1, CAPTURE=2, DONE=3
//   Count              : number of records held, 0..DEPTH
module pipe_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          Arm,
    input  logic          TrigEn,
    input  logic [31:0]   TrigPC,
    input  logic [31:0]   PC,
    input  logic [31:0]   IF_Inst,
    input  logic [31:0]   WB_Alu,
    output logic [31:0]   Rd_Data,
    output logic          Rd_Valid,
    input  logic          Rd_Ready,
    output logic          Rd_Last,
    output logic [1:0]    State,
    output logic [AW:0]   Count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam int            CW       = AW + 1;
    localparam logic [AW:0]   LAST_WR  = CW'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_REC = AW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] rd_rec_q, rd_rec_d;
    logic [1:0]    rd_word_q, rd_word_d;
    logic          wr_en;
    logic          trig_hit;
    logic          xfer;
    logic [95:0]   rd_record;

    logic [95:0]   trace_mem [DEPTH];

    assign trig_hit = !TrigEn || (PC == TrigPC);
    assign xfer     = Rd_Valid && Rd_Ready;
    assign State    = state_q;
    assign Count    = count_q;

    // State register and indices.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= IDLE;
            count_q   <= '0;
            rd_rec_q  <= '0;
            rd_word_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rd_rec_q  <= rd_rec_d;
            rd_word_q <= rd_word_d;
        end
    end

    // Trace storage. Records are written at the current Count, so the write
    // pointer is Count's low bits and cannot wrap inside a window.
    // NOTE: the buffer has no reset; its contents are only read back after a
    // full window has been written, which keeps it a plain RAM.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            trace_mem[count_q[AW-1:0]] <= {PC, IF_Inst, WB_Alu};
        end
    end

    // Next-state logic.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rd_rec_d  = rd_rec_q;
        rd_word_d = rd_word_q;
        wr_en     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A trigger match in the Arm cycle is deliberately not evaluated.
                if (Arm) begin
                    state_d   = ARMED;
                    count_d   = '0;
                    rd_rec_d  = '0;
                    rd_word_d = '0;
                end
            end
            ARMED: begin
                if (trig_hit) begin
                    wr_en   = 1'b1;
                    count_d = count_q + CW'(1);
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                wr_en   = 1'b1;
                count_d = count_q + CW'(1);
                if (count_q == LAST_WR) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Arm takes priority over any transfer, including the last one.
                if (Arm) begin
                    state_d   = ARMED;
                    count_d   = '0;
                    rd_rec_d  = '0;
                    rd_word_d = '0;
                end else if (xfer) begin
                    if (rd_word_q == 2'd2) begin
                        rd_word_d = '0;
                        if (Rd_Last) begin
                            state_d  = IDLE;
                            count_d  = '0;
                            rd_rec_d = '0;
                        end else begin
                            rd_rec_d = rd_rec_q + AW'(1);
                        end
                    end else begin
                        rd_word_d = rd_word_q + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Readout outputs. DONE only ever holds unread words, since the final
    // transfer leaves the state.
    always_comb begin
        rd_record = trace_mem[rd_rec_q];
        Rd_Valid  = (state_q == DONE);
        Rd_Last   = Rd_Valid && (rd_rec_q == LAST_REC) && (rd_word_q == 2'd2);
        Rd_Data   = '0;
        if (Rd_Valid) begin
            unique case (rd_word_q)
                2'd0:    Rd_Data = rd_record[95:64];
                2'd1:    Rd_Data = rd_record[63:32];
                default: Rd_Data = rd_record[31:0];
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed bench for pipe_trace_buffer. Captured samples are pushed to a
// scoreboard queue as they are driven and popped as words are read out.
module tb_pipe_trace_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int NWORD = 3 * DEPTH;

    logic          Clock = 1'b0;
    logic          Resetn;
    logic          Arm;
    logic          TrigEn;
    logic [31:0]   TrigPC;
    logic [31:0]   PC;
    logic [31:0]   IF_Inst;
    logic [31:0]   WB_Alu;
    logic [31:0]   Rd_Data;
    logic          Rd_Valid;
    logic          Rd_Ready;
    logic          Rd_Last;
    logic [1:0]    State;
    logic [AW:0]   Count;

    int            n_checks = 0;
    int            n_errors = 0;
    int            word_idx = 0;
    logic [31:0]   sb[$];

    pipe_trace_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .Arm     (Arm),
        .TrigEn  (TrigEn),
        .TrigPC  (TrigPC),
        .PC      (PC),
        .IF_Inst (IF_Inst),
        .WB_Alu  (WB_Alu),
        .Rd_Data (Rd_Data),
        .Rd_Valid(Rd_Valid),
        .Rd_Ready(Rd_Ready),
        .Rd_Last (Rd_Last),
        .State   (State),
        .Count   (Count)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Drive one CPU sample for a cycle; if it should land in the window,
    // its three words go to the scoreboard in readout order.
    task automatic drive_cycle(input logic [31:0] pc, input bit captured);
        PC      = pc;
        IF_Inst = $urandom;
        WB_Alu  = $urandom;
        if (captured) begin
            sb.push_back(PC);
            sb.push_back(IF_Inst);
            sb.push_back(WB_Alu);
        end
        tick();
    endtask

    // Read n words. With stall set, Rd_Ready follows a 1,0,0,1 pattern and
    // Rd_Data must hold while a word is offered but not accepted.
    task automatic read_words(input int n, input bit stall);
        int          got     = 0;
        int          cyc     = 0;
        bit          holding = 0;
        logic [31:0] held    = '0;
        logic [31:0] exp_w;
        while (got < n && cyc < 1000) begin
            Rd_Ready = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            if (!Rd_Valid) begin
                check("rd_valid_in_readout", Rd_Valid, 1'b1);
                break;
            end
            if (holding) check("stall_stable", Rd_Data, held);
            if (Rd_Ready) begin
                exp_w = (sb.size() > 0) ? sb.pop_front() : 32'hBAD0BAD0;
                check("rd_data", Rd_Data, exp_w);
                check("rd_last", Rd_Last, word_idx == NWORD - 1);
                word_idx++;
                got++;
                holding = 0;
            end else begin
                held    = Rd_Data;
                holding = 1;
            end
            tick();
            cyc++;
        end
        check("read_budget", got, n);
        Rd_Ready = 1'b0;
    endtask

    initial begin
        Resetn   = 1'b0;
        Arm      = 1'b0;
        TrigEn   = 1'b0;
        TrigPC   = '0;
        PC       = '0;
        IF_Inst  = '0;
        WB_Alu   = '0;
        Rd_Ready = 1'b0;

        // Reset values
        #23;
        check("rst_state", State, 2'd0);
        check("rst_count", Count, 0);
        check("rst_valid", Rd_Valid, 1'b0);
        check("rst_last", Rd_Last, 1'b0);
        check("rst_data", Rd_Data, 32'h0);
        Resetn = 1'b1;
        tick();

        // 1: immediate capture, PC 0x00,0x04,... and straight readout
        Arm = 1'b1; TrigEn = 1'b0; PC = 32'hDEAD0000;
        tick();
        Arm = 1'b0;
        check("t1_armed", State, 2'd1);
        check("t1_armed_count", Count, 0);
        for (int k = 0; k < DEPTH; k++) begin
            drive_cycle(32'(4 * k), 1'b1);
            if (k == 0) begin
                check("t1_capture", State, 2'd2);
                check("t1_count1", Count, 1);
            end
        end
        check("t1_done", State, 2'd3);
        check("t1_count16", Count, DEPTH);
        PC = 32'hFFFF0000;
        word_idx = 0;
        read_words(NWORD, 1'b0);
        check("t1_idle", State, 2'd0);
        check("t1_count0", Count, 0);
        check("t1_valid0", Rd_Valid, 1'b0);

        // 2+3: PC trigger at 0x20 (matching PC during Arm is ignored), stalled readout
        TrigEn = 1'b1; TrigPC = 32'h20;
        Arm = 1'b1; PC = 32'h20;
        tick();
        Arm = 1'b0;
        check("t2_arm_only", State, 2'd1);
        check("t2_arm_count", Count, 0);
        for (int k = 0; k < 24; k++) begin
            drive_cycle(32'(4 * k), k >= 8);
            if (k < 8) check("t2_hold_armed", State, 2'd1);
        end
        check("t2_done", State, 2'd3);
        check("t2_count16", Count, DEPTH);
        word_idx = 0;
        read_words(NWORD, 1'b1);
        check("t2_idle", State, 2'd0);

        // 4: Arm during CAPTURE at Count=5 is ignored
        TrigEn = 1'b0;
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k == 5) begin
                check("t4_count5", Count, 5);
                Arm = 1'b1;
            end
            drive_cycle(32'h1000 + 32'(4 * k), 1'b1);
            Arm = 1'b0;
            if (k == 5) begin
                check("t4_no_restart_state", State, 2'd2);
                check("t4_no_restart_count", Count, 6);
            end
        end
        check("t4_done", State, 2'd3);
        check("t4_count16", Count, DEPTH);
        word_idx = 0;
        read_words(NWORD, 1'b0);

        // 5: Arm in DONE after 10 words aborts the readout
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
        for (int k = 0; k < DEPTH; k++) drive_cycle(32'h2000 + 32'(4 * k), 1'b1);
        word_idx = 0;
        read_words(10, 1'b0);
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
        check("t5_abort_state", State, 2'd1);
        check("t5_abort_count", Count, 0);
        check("t5_abort_valid", Rd_Valid, 1'b0);
        sb.delete();
        for (int k = 0; k < DEPTH; k++) drive_cycle(32'h3000 + 32'(4 * k), 1'b1);
        check("t5_new_done", State, 2'd3);
        word_idx = 0;
        read_words(NWORD - 1, 1'b0);

        // Arm beats a simultaneous transfer of the last word
        check("t5_last_pending", Rd_Last, 1'b1);
        Rd_Ready = 1'b1;
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
        Rd_Ready = 1'b0;
        check("t5_arm_wins", State, 2'd1);
        check("t5_arm_wins_count", Count, 0);
        sb.delete();

        // 6: async reset mid-readout at word 20
        for (int k = 0; k < DEPTH; k++) drive_cycle(32'h4000 + 32'(4 * k), 1'b1);
        word_idx = 0;
        read_words(20, 1'b0);
        #3;
        Resetn = 1'b0;
        #1;
        check("t6_rst_state", State, 2'd0);
        check("t6_rst_count", Count, 0);
        check("t6_rst_valid", Rd_Valid, 1'b0);
        check("t6_rst_last", Rd_Last, 1'b0);
        check("t6_rst_data", Rd_Data, 32'h0);
        tick();
        #2;
        Resetn = 1'b1;
        tick();
        check("t6_post_state", State, 2'd0);
        check("t6_post_valid", Rd_Valid, 1'b0);
        check("t6_post_count", Count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
